// File: rtl/sg_dma_chan_sched.sv
// sg_dma_chan_sched: splits per-channel transfer requests into descriptors of at most
//   MAX_CHUNK beats and grants them round-robin, with one descriptor outstanding at a time.
// Latency: accept->desc_valid 2 cycles from IDLE; dma_done->cmp_valid 1; dma_done->next desc 2.
// Backpressure: descriptor held stable until desc_ready; req_ready low while a context is busy;
//   cmp_valid is a pulse with no backpressure.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_addr/req_len    per-channel request (channel i in slice i), req_ready = context free
//   ch_en                         per-channel arbitration enable (disabled context is kept, skipped)
//   desc_valid/addr/len, desc_ready  descriptor to the DMA read engine
//   dma_done                      pulse: DMA finished the last accepted descriptor
//   cmp_valid/cmp_ch              per-request completion pulse
//   busy                          FSM not in IDLE
module sg_dma_chan_sched #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_CHUNK  = 256,
  parameter int BEAT_BYTES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              ch_en,
  output logic                           desc_valid,
  output logic [ADDR_WIDTH-1:0]          desc_addr,
  output logic [LEN_WIDTH-1:0]           desc_len,
  input  logic                           desc_ready,
  input  logic                           dma_done,
  output logic                           cmp_valid,
  output logic [$clog2(NUM_CH)-1:0]      cmp_ch,
  output logic                           busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [LEN_WIDTH-1:0]  LP_MAX_CHUNK  = LEN_WIDTH'(MAX_CHUNK);
  localparam logic [ADDR_WIDTH-1:0] LP_BEAT_BYTES = ADDR_WIDTH'(BEAT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nx;

  logic [NUM_CH-1:0]     r_active;
  logic [ADDR_WIDTH-1:0] r_cur_addr [NUM_CH];
  logic [LEN_WIDTH-1:0]  r_rem_len  [NUM_CH];
  logic [CH_W-1:0]       r_rr_ptr;
  logic [CH_W-1:0]       r_gnt_ch;
  logic [ADDR_WIDTH-1:0] r_desc_addr;
  logic [LEN_WIDTH-1:0]  r_desc_len;
  logic                  r_cmp_valid;
  logic [CH_W-1:0]       r_cmp_ch;

  logic [NUM_CH-1:0]     w_acc;
  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_done_clr;
  logic                  w_any_elig;
  logic                  w_found;
  logic [CH_W-1:0]       w_idx;
  logic [CH_W-1:0]       w_gnt;
  logic                  w_gnt_zero;
  logic                  w_last_chunk;
  logic [LEN_WIDTH-1:0]  w_chunk_len;

  assign w_acc      = req_valid & ~r_active;
  assign w_elig     = r_active & ch_en;
  assign w_any_elig = |w_elig;

  // Round-robin: first eligible channel strictly after r_rr_ptr, wrapping.
  always_comb begin
    w_gnt   = r_rr_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_gnt_zero   = (r_rem_len[w_gnt] == '0);
  assign w_chunk_len  = (r_rem_len[w_gnt] > LP_MAX_CHUNK) ? LP_MAX_CHUNK : r_rem_len[w_gnt];
  // The outstanding chunk is the last one when it covers everything that remains.
  assign w_last_chunk = (r_rem_len[r_gnt_ch] == r_desc_len);

  always_comb begin
    w_state_nx = r_state;
    w_done_clr = '0;
    case (r_state)
      // Requests accepted this edge count, so ARB follows the accept edge directly.
      S_IDLE: if (|((r_active | w_acc) & ch_en)) w_state_nx = S_ARB;
      S_ARB: begin
        if (!w_any_elig)     w_state_nx = S_IDLE;
        else if (w_gnt_zero) w_state_nx = S_ARB;
        else                 w_state_nx = S_ISSUE;
      end
      S_ISSUE: if (desc_ready) w_state_nx = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (dma_done) begin
          if (w_last_chunk) w_done_clr[r_gnt_ch] = 1'b1;
          w_state_nx = (|(((r_active & ~w_done_clr) | w_acc) & ch_en)) ? S_ARB : S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= '0;
      r_rr_ptr    <= CH_W'(NUM_CH - 1);
      r_gnt_ch    <= '0;
      r_desc_addr <= '0;
      r_desc_len  <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cur_addr[i] <= '0;
        r_rem_len[i]  <= '0;
      end
    end else begin
      r_cmp_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_acc[i]) begin
          r_active[i]   <= 1'b1;
          r_cur_addr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_rem_len[i]  <= req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      if (r_state == S_ARB && w_any_elig) begin
        r_rr_ptr <= w_gnt;
        r_gnt_ch <= w_gnt;
        if (w_gnt_zero) begin
          // Zero-length request completes without touching the DMA.
          r_active[w_gnt] <= 1'b0;
          r_cmp_valid     <= 1'b1;
          r_cmp_ch        <= w_gnt;
        end else begin
          r_desc_addr <= r_cur_addr[w_gnt];
          r_desc_len  <= w_chunk_len;
        end
      end
      if (r_state == S_WAIT_DONE && dma_done) begin
        r_rem_len[r_gnt_ch]  <= r_rem_len[r_gnt_ch] - r_desc_len;
        r_cur_addr[r_gnt_ch] <= r_cur_addr[r_gnt_ch] + ADDR_WIDTH'(r_desc_len) * LP_BEAT_BYTES;
        if (w_last_chunk) begin
          r_active[r_gnt_ch] <= 1'b0;
          r_cmp_valid        <= 1'b1;
          r_cmp_ch           <= r_gnt_ch;
        end
      end
    end
  end

  assign req_ready  = ~r_active;
  assign desc_valid = (r_state == S_ISSUE);
  assign desc_addr  = r_desc_addr;
  assign desc_len   = r_desc_len;
  assign cmp_valid  = r_cmp_valid;
  assign cmp_ch     = r_cmp_ch;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sg_dma_chan_sched.sv
// tb_sg_dma_chan_sched: directed stimulus with a scoreboard for descriptors and completions.
// A DMA responder model accepts descriptors and returns dma_done after a programmable delay.
// The monitor pops expected entries whenever a descriptor handshake or completion is seen.
module tb_sg_dma_chan_sched;
  localparam int NUM_CH = 4;
  localparam int AW     = 64;
  localparam int LW     = 16;
  localparam int CHW    = 2;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] len;
  } desc_exp_t;

  typedef struct packed {
    int ch;
    int cyc;   // -1: one cycle after the most recent dma_done
  } cmp_exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*AW-1:0] req_addr;
  logic [NUM_CH*LW-1:0] req_len;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    ch_en;
  logic                 desc_valid;
  logic [AW-1:0]        desc_addr;
  logic [LW-1:0]        desc_len;
  logic                 desc_ready;
  logic                 dma_done;
  logic                 cmp_valid;
  logic [CHW-1:0]       cmp_ch;
  logic                 busy;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        last_done_cyc = -100;
  int        dma_lat = 1;
  int        dma_cnt = -1;
  logic      rdy_en = 1'b1;
  int        k;
  desc_exp_t exp_desc[$];
  cmp_exp_t  exp_cmp[$];

  sg_dma_chan_sched #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_CHUNK(256), .BEAT_BYTES(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .ch_en(ch_en),
    .desc_valid(desc_valid), .desc_addr(desc_addr), .desc_len(desc_len), .desc_ready(desc_ready),
    .dma_done(dma_done),
    .cmp_valid(cmp_valid), .cmp_ch(cmp_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int ch, input logic [63:0] a, input logic [15:0] l);
    req_valid[ch]        = 1'b1;
    req_addr[ch*AW +: AW] = a;
    req_len[ch*LW +: LW]  = l;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_desc.size() != 0 || exp_cmp.size() != 0) && n < 2000) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0d desc_left=%0d cmp_left=%0d, expected all drained",
               name, busy, exp_desc.size(), exp_cmp.size());
    end
  endtask

  task automatic wait_desc(input string name);
    int n;
    n = 0;
    @(negedge clk); #2;
    while (!desc_valid && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_desc_timeout: desc_valid=0, expected 1 within 50 cycles", name);
    end
  endtask

  // DMA responder: drives desc_ready from rdy_en and pulses dma_done dma_lat cycles
  // after the cycle following a handshake.
  initial begin
    dma_done   = 1'b0;
    desc_ready = 1'b1;
    forever begin
      @(negedge clk); #1;
      dma_done   = 1'b0;
      desc_ready = rdy_en;
      if (rst) begin
        dma_cnt = -1;
      end else begin
        if (dma_cnt == 0) begin
          dma_done      = 1'b1;
          last_done_cyc = cyc;
          dma_cnt       = -1;
        end else if (dma_cnt > 0) begin
          dma_cnt--;
        end
        if (desc_valid && desc_ready) dma_cnt = dma_lat;
      end
    end
  end

  // Monitor: compares every descriptor handshake and completion against the scoreboard.
  initial begin
    desc_exp_t d;
    cmp_exp_t  c;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (desc_valid && desc_ready) begin
          if (exp_desc.size() == 0) begin
            checks++; errors++;
            $display("FAIL desc_unexpected: got addr 0x%0h len %0d, expected no descriptor", desc_addr, desc_len);
          end else begin
            d = exp_desc.pop_front();
            chk("desc_addr", desc_addr, d.addr);
            chk("desc_len", 64'(desc_len), 64'(d.len));
          end
        end
        if (cmp_valid) begin
          if (exp_cmp.size() == 0) begin
            checks++; errors++;
            $display("FAIL cmp_unexpected: got cmp_ch %0d, expected no completion", cmp_ch);
          end else begin
            c = exp_cmp.pop_front();
            chk("cmp_ch", 64'(cmp_ch), 64'(c.ch));
            chk("cmp_cycle", 64'(cyc), 64'((c.cyc < 0) ? last_done_cyc + 1 : c.cyc));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    ch_en     = '1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'hf);
    chk("rst_desc_valid", 64'(desc_valid), 64'd0);
    chk("rst_desc_addr", desc_addr, 64'd0);
    chk("rst_desc_len", 64'(desc_len), 64'd0);
    chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    chk("rst_cmp_ch", 64'(cmp_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Round-robin: ch0 and ch2 both len 512, same cycle.
    @(negedge clk);
    exp_desc.push_back('{64'h0000_0000, 16'd256});
    exp_desc.push_back('{64'h0010_0000, 16'd256});
    exp_desc.push_back('{64'h0000_4000, 16'd256});
    exp_desc.push_back('{64'h0010_4000, 16'd256});
    exp_cmp.push_back('{0, -1});
    exp_cmp.push_back('{2, -1});
    set_req(0, 64'h0000_0000, 16'd512);
    set_req(2, 64'h0010_0000, 16'd512);
    @(negedge clk); req_valid = '0;
    wait_idle("rr");

    // Single channel, 600 beats: 256 + 256 + 88.
    @(negedge clk);
    exp_desc.push_back('{64'h1000, 16'd256});
    exp_desc.push_back('{64'h5000, 16'd256});
    exp_desc.push_back('{64'h9000, 16'd88});
    exp_cmp.push_back('{0, -1});
    set_req(0, 64'h1000, 16'd600);
    @(negedge clk); req_valid = '0; #2;
    chk("single_arb_busy", 64'(busy), 64'd1);
    chk("single_arb_no_desc", 64'(desc_valid), 64'd0);
    chk("single_req_ready_low", 64'(req_ready), 64'he);
    @(negedge clk); #2;
    chk("single_accept_to_desc", 64'(desc_valid), 64'd1);
    wait_idle("single");
    chk("single_req_ready_back", 64'(req_ready), 64'hf);

    // Backpressure: desc_ready low while the descriptor waits.
    @(negedge clk);
    rdy_en = 1'b0;
    exp_desc.push_back('{64'h2000, 16'd5});
    exp_cmp.push_back('{3, -1});
    set_req(3, 64'h2000, 16'd5);
    @(negedge clk); req_valid = '0;
    wait_desc("bp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", 64'(desc_valid), 64'd1);
      chk("bp_addr_held", desc_addr, 64'h2000);
      chk("bp_len_held", 64'(desc_len), 64'd5);
      @(negedge clk); #2;
    end
    rdy_en = 1'b1;
    wait_idle("bp");

    // Zero length on ch1: completion two cycles after the accept cycle, no descriptor.
    @(negedge clk);
    set_req(1, 64'hdead_0000, 16'd0);
    k = cyc;
    exp_cmp.push_back('{1, k + 2});
    @(negedge clk); req_valid = '0; #2;
    chk("zero_ready_low", 64'(req_ready[1]), 64'd0);
    @(negedge clk); #2;
    chk("zero_ready_back", 64'(req_ready[1]), 64'd1);
    wait_idle("zero");

    // ch_en mask: ch0 1024 beats, disabled after its first chunk, then resumed.
    @(negedge clk);
    dma_lat = 3;
    exp_desc.push_back('{64'h0, 16'd256});
    set_req(0, 64'h0, 16'd1024);
    @(negedge clk); req_valid = '0;
    wait_desc("mask");
    ch_en[0] = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    chk("mask_busy_low", 64'(busy), 64'd0);
    chk("mask_no_desc", 64'(desc_valid), 64'd0);
    chk("mask_ctx_kept", 64'(req_ready[0]), 64'd0);
    exp_desc.push_back('{64'h4000, 16'd256});
    exp_desc.push_back('{64'h8000, 16'd256});
    exp_desc.push_back('{64'hC000, 16'd256});
    exp_cmp.push_back('{0, -1});
    @(negedge clk); ch_en[0] = 1'b1;
    wait_idle("mask");
    dma_lat = 1;

    // Reset while a descriptor is outstanding.
    @(negedge clk);
    dma_lat = 6;
    exp_desc.push_back('{64'h3000, 16'd10});
    set_req(2, 64'h3000, 16'd10);
    @(negedge clk); req_valid = '0;
    wait_desc("rst_mid");
    @(negedge clk); #2;
    chk("rst_mid_busy_before", 64'(busy), 64'd1);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_mid_desc_valid", 64'(desc_valid), 64'd0);
    chk("rst_mid_cmp_valid", 64'(cmp_valid), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'hf);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    chk("rst_mid_stays_idle", 64'(busy), 64'd0);
    dma_lat = 1;

    chk("scoreboard_empty", 64'(exp_desc.size() + exp_cmp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
